debounce_edge: RTL and testbench

- Downstream consumer of the single-bit D flip-flop stage. Takes its registered output `q` as `din` and produces a glitch-filtered level.
- Emits one-cycle rise/fall pulses and keeps a running count of accepted rising edges.
- Used to clean up slow or noisy single-bit signals before they reach control logic in the practice datapath.

---
 rtl/debounce_edge_pkg.sv | 18 +
 rtl/dbnc_timer.sv | 38 +++
 rtl/debounce_edge.sv | 129 ++++++++++++
 tb/tb_debounce_edge.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/debounce_edge_pkg.sv
// Shared definitions for the debounce/edge-detect block: state encodings,
// default debounce length and the timer width helper.
package debounce_edge_pkg;

    localparam logic [1:0] S_LOW    = 2'd0;
    localparam logic [1:0] S_WAIT_H = 2'd1;
    localparam logic [1:0] S_HIGH   = 2'd2;
    localparam logic [1:0] S_WAIT_L = 2'd3;

    localparam int DB_CYCLES_DEFAULT = 4;

    function automatic int timer_width(input int db_cycles);
        int w;
        w = $clog2(db_cycles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dbnc_timer.sv
// Debounce qualification timer: counts stable cycles while a new input value
// is being confirmed; done flags the last qualifying cycle.
module dbnc_timer
    import debounce_edge_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic done
);

    localparam int TW = timer_width(DB_CYCLES);

    logic [TW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == TW'(DB_CYCLES - 1));

endmodule

// File: rtl/debounce_edge.sv
// Glitch filter for a slow single-bit input with registered rise/fall pulses
// and a count of accepted rising edges.
//
//   state    | meaning
//   S_LOW    | level 0, input stable low
//   S_WAIT_H | level 0, input seen high, qualifying
//   S_HIGH   | level 1, input stable high
//   S_WAIT_L | level 1, input seen low, qualifying
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CW        = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din,
    input  logic          en,
    input  logic          clr,
    output logic          level,
    output logic          rise,
    output logic          fall,
    output logic          busy,
    output logic [CW-1:0] edge_cnt
);

    logic          din_r_q;
    logic [1:0]    state_q, state_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] edge_cnt_q, edge_cnt_d;
    logic          tmr_clear, tmr_inc, tmr_done;

    dbnc_timer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (tmr_clear),
        .inc   (tmr_inc),
        .done  (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        tmr_clear = 1'b0;
        tmr_inc   = 1'b0;
        rise_d    = 1'b0;
        fall_d    = 1'b0;
        if (en) begin
            case (state_q)
                S_LOW: begin
                    if (din_r_q) begin
                        state_d   = S_WAIT_H;
                        tmr_clear = 1'b1;
                    end
                end
                S_WAIT_H: begin
                    if (!din_r_q) begin
                        state_d   = S_LOW;
                        tmr_clear = 1'b1;
                    end else if (tmr_done) begin
                        state_d   = S_HIGH;
                        rise_d    = 1'b1;
                        tmr_clear = 1'b1;
                    end else begin
                        tmr_inc   = 1'b1;
                    end
                end
                S_HIGH: begin
                    if (!din_r_q) begin
                        state_d   = S_WAIT_L;
                        tmr_clear = 1'b1;
                    end
                end
                S_WAIT_L: begin
                    if (din_r_q) begin
                        state_d   = S_HIGH;
                        tmr_clear = 1'b1;
                    end else if (tmr_done) begin
                        state_d   = S_LOW;
                        fall_d    = 1'b1;
                        tmr_clear = 1'b1;
                    end else begin
                        tmr_inc   = 1'b1;
                    end
                end
                default: begin
                    state_d   = S_LOW;
                    tmr_clear = 1'b1;
                end
            endcase
        end
    end

    // clr takes priority over a coincident rise
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (clr) begin
            edge_cnt_d = '0;
        end else if (rise_d) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_r_q    <= 1'b0;
            state_q    <= S_LOW;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            edge_cnt_q <= '0;
        end else begin
            din_r_q    <= din;
            state_q    <= state_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

    // Encoding puts the debounced level in bit 1 and "qualifying" in bit 0.
    assign level    = state_q[1];
    assign busy     = state_q[0];
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign edge_cnt = edge_cnt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: per-cycle vector table for the
// default instance plus directed sequences for reset, wrap and DB_CYCLES=1.
module tb_debounce_edge;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       din   = 1'b1;
    logic       din_b = 1'b0;
    logic       en    = 1'b1;
    logic       clr   = 1'b0;

    logic       level_a, rise_a, fall_a, busy_a;
    logic [7:0] cnt_a;
    logic       level_b, rise_b, fall_b, busy_b;
    logic [7:0] cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int rise_seen;

    typedef struct {
        logic       din, en, clr;
        logic       lvl, rise, fall, busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t tv[$];

    debounce_edge #(.DB_CYCLES(4), .CW(8)) u_dut_a (
        .clk(clk), .rst(rst), .din(din), .en(en), .clr(clr),
        .level(level_a), .rise(rise_a), .fall(fall_a), .busy(busy_a),
        .edge_cnt(cnt_a)
    );

    debounce_edge #(.DB_CYCLES(1), .CW(8)) u_dut_b (
        .clk(clk), .rst(rst), .din(din_b), .en(en), .clr(clr),
        .level(level_b), .rise(rise_b), .fall(fall_b), .busy(busy_b),
        .edge_cnt(cnt_b)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic d, input logic e, input logic c,
                       input logic l, input logic r, input logic f,
                       input logic b, input logic [7:0] n);
        vec_t v;
        v.din = d; v.en = e; v.clr = c;
        v.lvl = l; v.rise = r; v.fall = f; v.busy = b; v.cnt = n;
        tv.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // din en clr | level rise fall busy cnt
        add(0,1,0, 0,0,0,0, 0);
        add(1,1,0, 0,0,0,0, 0);   // 3-cycle glitch
        add(1,1,0, 0,0,0,1, 0);
        add(1,1,0, 0,0,0,1, 0);
        add(0,1,0, 0,0,0,1, 0);
        add(0,1,0, 0,0,0,0, 0);
        add(0,1,0, 0,0,0,0, 0);
        add(1,1,0, 0,0,0,0, 0);   // 5-cycle pulse, accepted
        add(1,1,0, 0,0,0,1, 0);
        add(1,1,0, 0,0,0,1, 0);
        add(1,1,0, 0,0,0,1, 0);
        add(1,1,0, 0,0,0,1, 0);
        add(0,1,0, 1,1,0,0, 1);
        add(0,1,0, 1,0,0,1, 1);
        add(0,1,0, 1,0,0,1, 1);
        add(0,1,0, 1,0,0,1, 1);
        add(0,1,0, 1,0,0,1, 1);
        add(0,1,0, 0,0,1,0, 1);
        add(0,1,0, 0,0,0,0, 1);
        add(1,1,0, 0,0,0,0, 1);   // 4-cycle pulse, rejected
        add(1,1,0, 0,0,0,1, 1);
        add(1,1,0, 0,0,0,1, 1);
        add(1,1,0, 0,0,0,1, 1);
        add(0,1,0, 0,0,0,1, 1);
        add(0,1,0, 0,0,0,0, 1);
        add(0,1,0, 0,0,0,0, 1);
        add(1,1,0, 0,0,0,0, 1);   // en dropped mid-qualification
        add(1,1,0, 0,0,0,1, 1);
        add(1,1,0, 0,0,0,1, 1);
        add(1,0,0, 0,0,0,1, 1);
        add(1,0,0, 0,0,0,1, 1);
        add(1,0,0, 0,0,0,1, 1);
        add(1,1,0, 0,0,0,1, 1);
        add(1,1,0, 0,0,0,1, 1);
        add(1,1,0, 1,1,0,0, 2);
        add(1,1,0, 1,0,0,0, 2);
        add(0,1,0, 1,0,0,0, 2);   // clean fall
        add(0,1,0, 1,0,0,1, 2);
        add(0,1,0, 1,0,0,1, 2);
        add(0,1,0, 1,0,0,1, 2);
        add(0,1,0, 1,0,0,1, 2);
        add(0,1,0, 0,0,1,0, 2);
        add(1,1,0, 0,0,0,0, 2);   // rise coinciding with clr
        add(1,1,0, 0,0,0,1, 2);
        add(1,1,0, 0,0,0,1, 2);
        add(1,1,0, 0,0,0,1, 2);
        add(1,1,0, 0,0,0,1, 2);
        add(1,1,1, 1,1,0,0, 0);
        add(1,1,0, 1,0,0,0, 0);

        // Reset held with din=1
        #15;
        chk("reset_hold", {level_a, rise_a, fall_a, busy_a, cnt_a}, 32'd0);
        #10 rst = 1'b0;

        // Clean rise after release: first edge is t0, acceptance on t0+5
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("rise_lat[%0d]", k), {level_a, rise_a, fall_a, busy_a},
                {(k >= 6), (k == 6), 1'b0, (k >= 2 && k <= 5)});
        end
        chk("rise_cnt", cnt_a, 32'd1);

        // Asynchronous mid-cycle reset
        #4 rst = 1'b1; din = 1'b0;
        #1 chk("async_rst", {level_a, rise_a, fall_a, busy_a, cnt_a}, 32'd0);
        #2 rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            din = tv[i].din;
            en  = tv[i].en;
            clr = tv[i].clr;
            step();
            chk($sformatf("vec[%0d]", i),
                {level_a, rise_a, fall_a, busy_a, cnt_a},
                {tv[i].lvl, tv[i].rise, tv[i].fall, tv[i].busy, tv[i].cnt});
        end
        clr = 1'b0;
        en  = 1'b1;

        // 256 accepted rises from cnt=0: wraps through 255 back to 0
        rise_seen = 0;
        for (int i = 1; i <= 256; i++) begin
            din = 1'b0;
            repeat (6) begin
                step();
                if (rise_a) rise_seen++;
            end
            din = 1'b1;
            repeat (6) begin
                step();
                if (rise_a) rise_seen++;
            end
            if (i == 255) chk("cnt_255", cnt_a, 32'd255);
            if (i == 256) chk("cnt_wrap", cnt_a, 32'd0);
        end
        chk("wrap_rises", rise_seen, 32'd256);

        // DB_CYCLES=1 instance
        din_b = 1'b1;
        step();
        chk("db1_e1", {level_b, rise_b, busy_b}, 32'b000);
        step();
        chk("db1_e2", {level_b, rise_b, busy_b}, 32'b001);
        step();
        chk("db1_e3", {level_b, rise_b, busy_b}, 32'b110);
        chk("db1_cnt", cnt_b, 32'd1);
        din_b = 1'b0;
        step();
        din_b = 1'b1;
        chk("db1_g1", {level_b, fall_b, busy_b}, 32'b100);
        step();
        chk("db1_g2", {level_b, fall_b, busy_b}, 32'b101);
        step();
        chk("db1_g3", {level_b, fall_b, busy_b}, 32'b100);
        step();
        chk("db1_g4", {level_b, fall_b, busy_b}, 32'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
